// File: rtl/sha_pkg.sv
// Shared SHA-2 definitions: word widths, Sigma0 rotation amounts and the
// bitwise majority function used by the round datapath.
package sha_pkg;

    localparam int SHA256_W = 32;
    localparam int SHA512_W = 64;

    localparam int SIG0_R0_256 = 2;
    localparam int SIG0_R1_256 = 13;
    localparam int SIG0_R2_256 = 22;

    localparam int SIG0_R0_512 = 28;
    localparam int SIG0_R1_512 = 34;
    localparam int SIG0_R2_512 = 39;

    // Sized for the widest word; narrower callers zero-extend and truncate.
    function automatic logic [SHA512_W-1:0] maj_f(
        input logic [SHA512_W-1:0] x,
        input logic [SHA512_W-1:0] y,
        input logic [SHA512_W-1:0] z
    );
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_maj_if.sv
// Operand/result bus of the majority block. Port t2 exists only when
// MAJ_SIGMA0_EN is defined.
interface sha256_maj_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] m;
    logic             out_valid;
`ifdef MAJ_SIGMA0_EN
    logic [WIDTH-1:0] t2;

    modport master (
        output in_valid, x, y, z,
        input  m, out_valid, t2
    );

    modport slave (
        input  in_valid, x, y, z,
        output m, out_valid, t2
    );
`else
    modport master (
        output in_valid, x, y, z,
        input  m, out_valid
    );

    modport slave (
        input  in_valid, x, y, z,
        output m, out_valid
    );
`endif
endinterface

// File: rtl/sha_sigma0.sv
// Combinational SHA-2 Sigma0 for 32- or 64-bit words. Only compiled when
// MAJ_SIGMA0_EN is defined, since nothing else instantiates it.
`ifdef MAJ_SIGMA0_EN
module sha_sigma0
    import sha_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] s
);

    localparam int R0 = (WIDTH == SHA512_W) ? SIG0_R0_512 : SIG0_R0_256;
    localparam int R1 = (WIDTH == SHA512_W) ? SIG0_R1_512 : SIG0_R1_256;
    localparam int R2 = (WIDTH == SHA512_W) ? SIG0_R2_512 : SIG0_R2_256;

    logic [WIDTH-1:0] rot0;
    logic [WIDTH-1:0] rot1;
    logic [WIDTH-1:0] rot2;

    assign rot0 = (x >> R0) | (x << (WIDTH - R0));
    assign rot1 = (x >> R1) | (x << (WIDTH - R1));
    assign rot2 = (x >> R2) | (x << (WIDTH - R2));
    assign s    = rot0 ^ rot1 ^ rot2;

endmodule
`endif

// File: rtl/sha256_maj.sv
// Registered SHA-2 majority with valid flag, one cycle of latency.
// Defining MAJ_SIGMA0_EN adds a registered t2 = Sigma0(x) + maj output.
module sha256_maj
    import sha_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    sha256_maj_if.slave  bus
);

    logic [WIDTH-1:0] maj_p0;
    logic [WIDTH-1:0] m_p1;
    logic             vld_p1;

    assign maj_p0 = WIDTH'(maj_f(SHA512_W'(bus.x), SHA512_W'(bus.y), SHA512_W'(bus.z)));

    // p0 -> p1: result holds while no new operand set arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                m_p1 <= maj_p0;
            end
        end
    end

    assign bus.m         = m_p1;
    assign bus.out_valid = vld_p1;

`ifdef MAJ_SIGMA0_EN
    logic [WIDTH-1:0] sig0_p0;
    logic [WIDTH-1:0] t2_p0;
    logic [WIDTH-1:0] t2_p1;

    sha_sigma0 #(
        .WIDTH (WIDTH)
    ) u_sigma0 (
        .x (bus.x),
        .s (sig0_p0)
    );

    assign t2_p0 = sig0_p0 + maj_p0;

    // p0 -> p1: t2 shares the valid, hold and reset behaviour of m
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t2_p1 <= '0;
        end else if (bus.in_valid) begin
            t2_p1 <= t2_p0;
        end
    end

    assign bus.t2 = t2_p1;
`endif

endmodule

// File: tb/tb_sha256_maj.sv
// Randomized self-checking bench for sha256_maj (WIDTH 32); t2 is checked
// when MAJ_SIGMA0_EN is defined.
module tb_sha256_maj;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [W-1:0] exp_m;
    logic [W-1:0] exp_t2;
    logic         exp_v;

    sha256_maj_if #(.WIDTH(W)) bus ();

    sha256_maj #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Each result bit is set when at least two of the three operand bits are.
    function automatic logic [W-1:0] ref_maj(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int votes;
            votes = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (votes >= 2);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] a, input int n);
        logic [2*W-1:0] d;
        d = {a, a} >> n;
        return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_sig0(input logic [W-1:0] a);
        return ref_rotr(a, 2) ^ ref_rotr(a, 13) ^ ref_rotr(a, 22);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".m"}, 64'(bus.m), 64'(exp_m));
        check({tag, ".vld"}, 64'(bus.out_valid), 64'(exp_v));
`ifdef MAJ_SIGMA0_EN
        check({tag, ".t2"}, 64'(bus.t2), 64'(exp_t2));
`endif
    endtask

    // Drive one operand set, let one rising edge pass, then check the outputs.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        @(negedge clk);
        bus.in_valid = v;
        bus.x = a;
        bus.y = b;
        bus.z = c;
        @(posedge clk);
        if (!rst_n) begin
            exp_m  = '0;
            exp_t2 = '0;
            exp_v  = 1'b0;
        end else begin
            exp_v = v;
            if (v) begin
                exp_m  = ref_maj(a, b, c);
                exp_t2 = ref_sig0(a) + exp_m;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        exp_m        = '0;
        exp_t2       = '0;
        exp_v        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.z        = '0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        #1;
        check_outputs("rst_now");

        // Reset held: clock edges with valid operands must not disturb outputs
        for (int i = 0; i < 4; i++) begin
            cycle("rst_hold", 1'b1, $urandom, $urandom, $urandom);
        end

        @(negedge clk);
        rst_n = 1'b1;

        cycle("vec_basic", 1'b1, 32'h0000FFFF, 32'h00FF00FF, 32'h33335555);
        check("vec_basic_const", 64'(bus.m), 64'h003355FF);

        cycle("all_ones", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("all_ones_const", 64'(bus.m), 64'hFFFFFFFF);
        cycle("one_of_three", 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0);
        check("one_of_three_const", 64'(bus.m), 64'h0);

        cycle("sig0_one", 1'b1, 32'h00000001, 32'h0, 32'h0);
`ifdef MAJ_SIGMA0_EN
        check("sig0_one_const", 64'(bus.t2), 64'h40080400);
`endif

        cycle("load", 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000);
        for (int i = 0; i < 3; i++) begin
            cycle("hold", 1'b0, $urandom, $urandom, $urandom);
        end

        // Random stream with mostly-valid traffic and occasionally shared operands
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] c;
            a = $urandom;
            b = $urandom;
            c = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            cycle("rand", ($urandom_range(0, 3) != 0), a, b, c);
        end

        // Reset between edges clears everything without a clock edge
        cycle("pre_rst", 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678);
        #2 rst_n = 1'b0;
        exp_m  = '0;
        exp_t2 = '0;
        exp_v  = 1'b0;
        #1;
        check_outputs("mid_rst");
        cycle("mid_rst_edge", 1'b1, $urandom, $urandom, $urandom);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 32'h0000FFFF, 32'h00FF00FF, 32'h33335555);
        cycle("post_rst_idle", 1'b0, 32'h0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
